// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the SAP-style controller-sequencer: opcodes, T-state
// encoding and control-word layout.
package cpu_ctrl_pkg;

  localparam logic [3:0] OPC_LDA = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_OUT = 4'b1110;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam int CW_W  = 12;
  localparam int C_CP  = 0;
  localparam int C_EP  = 1;
  localparam int C_IMR = 2;
  localparam int C_ICE = 3;
  localparam int C_ILI = 4;
  localparam int C_IEI = 5;
  localparam int C_ILA = 6;
  localparam int C_EA  = 7;
  localparam int C_SU  = 8;
  localparam int C_EU  = 9;
  localparam int C_ILB = 10;
  localparam int C_ILO = 11;

  typedef logic [CW_W-1:0] ctrl_t;

  // Active-low strobes sit at 1 when idle; everything else at 0.
  localparam ctrl_t CW_INACTIVE = ctrl_t'((1 << C_IMR) | (1 << C_ICE) | (1 << C_ILI) |
                                          (1 << C_IEI) | (1 << C_ILA) | (1 << C_ILB) |
                                          (1 << C_ILO));

endpackage

// File: rtl/ctrl_decode.sv
// Combinational micro-op decode: (T-state, opcode) -> control word.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] OP_LDA = OPC_LDA,
  parameter logic [3:0] OP_ADD = OPC_ADD,
  parameter logic [3:0] OP_SUB = OPC_SUB,
  parameter logic [3:0] OP_OUT = OPC_OUT
) (
  input  state_t     state,
  input  logic [3:0] opcode,
  output ctrl_t      cw
);

  logic is_lda, is_add, is_sub, is_out, is_alu;

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_out = (opcode == OP_OUT);
  assign is_alu = is_add | is_sub;

  always_comb begin
    cw = CW_INACTIVE;
    case (state)
      S_T1: begin
        cw[C_EP]  = 1'b1;
        cw[C_IMR] = 1'b0;
      end
      S_T2: cw[C_CP] = 1'b1;
      S_T3: begin
        cw[C_ICE] = 1'b0;
        cw[C_ILI] = 1'b0;
      end
      S_T4: begin
        if (is_lda | is_alu) begin
          cw[C_IEI] = 1'b0;
          cw[C_IMR] = 1'b0;
        end
        if (is_out) begin
          cw[C_EA]  = 1'b1;
          cw[C_ILO] = 1'b0;
        end
      end
      S_T5: begin
        if (is_lda | is_alu) cw[C_ICE] = 1'b0;
        if (is_lda)          cw[C_ILA] = 1'b0;
        if (is_alu)          cw[C_ILB] = 1'b0;
      end
      S_T6: begin
        if (is_alu) begin
          cw[C_EU]  = 1'b1;
          cw[C_ILA] = 1'b0;
        end
        if (is_sub) cw[C_SU] = 1'b1;
      end
      default: cw = CW_INACTIVE;
    endcase
  end

endmodule

// File: rtl/controller_sequencer.sv
// Six-T-state ring sequencer with run/step gating; owns state, t_state and HLT.
module controller_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] OP_LDA = OPC_LDA,
  parameter logic [3:0] OP_ADD = OPC_ADD,
  parameter logic [3:0] OP_SUB = OPC_SUB,
  parameter logic [3:0] OP_OUT = OPC_OUT,
  parameter logic [3:0] OP_HLT = OPC_HLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] opcode,
  output logic       CP,
  output logic       EP,
  output logic       IMR,
  output logic       ICE,
  output logic       ILI,
  output logic       IEI,
  output logic       ILA,
  output logic       EA,
  output logic       SU,
  output logic       EU,
  output logic       ILB,
  output logic       ILO,
  output logic       HLT,
  output logic [5:0] t_state
);

  state_t state, state_nxt;
  ctrl_t  cw_dec, cw;
  logic   en;

  assign en = run | step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        S_IDLE:  state_nxt = S_T1;
        S_T1:    state_nxt = S_T2;
        S_T2:    state_nxt = S_T3;
        S_T3:    state_nxt = S_T4;
        S_T4:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_T5;
        S_T5:    state_nxt = S_T6;
        S_T6:    state_nxt = S_T1;
        default: state_nxt = S_HALT;
      endcase
    end
  end

  ctrl_decode #(
    .OP_LDA(OP_LDA),
    .OP_ADD(OP_ADD),
    .OP_SUB(OP_SUB),
    .OP_OUT(OP_OUT)
  ) u_decode (
    .state (state),
    .opcode(opcode),
    .cw    (cw_dec)
  );

  // A frozen T-state must not strobe the datapath, or the micro-op would repeat.
  assign cw = en ? cw_dec : CW_INACTIVE;

  assign CP  = cw[C_CP];
  assign EP  = cw[C_EP];
  assign IMR = cw[C_IMR];
  assign ICE = cw[C_ICE];
  assign ILI = cw[C_ILI];
  assign IEI = cw[C_IEI];
  assign ILA = cw[C_ILA];
  assign EA  = cw[C_EA];
  assign SU  = cw[C_SU];
  assign EU  = cw[C_EU];
  assign ILB = cw[C_ILB];
  assign ILO = cw[C_ILO];

  assign HLT = (state == S_HALT);

  always_comb begin
    t_state = 6'b000000;
    case (state)
      S_T1:    t_state = 6'b000001;
      S_T2:    t_state = 6'b000010;
      S_T3:    t_state = 6'b000100;
      S_T4:    t_state = 6'b001000;
      S_T5:    t_state = 6'b010000;
      S_T6:    t_state = 6'b100000;
      default: t_state = 6'b000000;
    endcase
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: instruction walks, pause/step, reset, halt.
module tb_controller_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run, step;
  logic [3:0] opcode;
  logic       CP, EP, IMR, ICE, ILI, IEI, ILA, EA, SU, EU, ILB, ILO, HLT;
  logic [5:0] t_state;

  int total = 0;
  int bad   = 0;

  // Expected words are inactive pattern XOR the asserted strobes.
  localparam logic [11:0] INACT = 12'h3E3;
  localparam logic [11:0] M_CP  = 12'h800, M_EP  = 12'h400, M_IMR = 12'h200,
                          M_ICE = 12'h100, M_ILI = 12'h080, M_IEI = 12'h040,
                          M_ILA = 12'h020, M_EA  = 12'h010, M_SU  = 12'h008,
                          M_EU  = 12'h004, M_ILB = 12'h002, M_ILO = 12'h001;

  localparam logic [5:0] T0 = 6'b000000, T1 = 6'b000001, T2 = 6'b000010,
                         T3 = 6'b000100, T4 = 6'b001000, T5 = 6'b010000,
                         T6 = 6'b100000;

  logic [11:0] cw;
  assign cw = {CP, EP, IMR, ICE, ILI, IEI, ILA, EA, SU, EU, ILB, ILO};

  controller_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .opcode(opcode),
    .CP(CP), .EP(EP), .IMR(IMR), .ICE(ICE), .ILI(ILI), .IEI(IEI), .ILA(ILA),
    .EA(EA), .SU(SU), .EU(EU), .ILB(ILB), .ILO(ILO), .HLT(HLT), .t_state(t_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] exp_cw,
                     input logic [5:0] exp_t, input logic exp_h);
    total++;
    assert (cw === exp_cw && t_state === exp_t && HLT === exp_h)
    else begin
      bad++;
      $error("FAIL %s: got ctl=%h t=%b hlt=%b, want ctl=%h t=%b hlt=%b",
             tag, cw, t_state, HLT, exp_cw, exp_t, exp_h);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; opcode = 4'b0000;
    #3;
    chk("reset", INACT, T0, 1'b0);
    rst_n = 1'b1; run = 1'b1;
    #1;
    chk("idle_run", INACT, T0, 1'b0);

    // LDA
    tick(); chk("lda_t1", INACT ^ M_EP ^ M_IMR, T1, 1'b0);
    tick(); chk("lda_t2", INACT ^ M_CP, T2, 1'b0);
    tick(); chk("lda_t3", INACT ^ M_ICE ^ M_ILI, T3, 1'b0);
    tick(); chk("lda_t4", INACT ^ M_IEI ^ M_IMR, T4, 1'b0);
    tick(); chk("lda_t5", INACT ^ M_ICE ^ M_ILA, T5, 1'b0);
    tick(); chk("lda_t6", INACT, T6, 1'b0);
    tick(); chk("lda_wrap_t1", INACT ^ M_EP ^ M_IMR, T1, 1'b0);

    // ADD
    opcode = 4'b0001;
    tick(); tick(); tick();
    chk("add_t4", INACT ^ M_IEI ^ M_IMR, T4, 1'b0);
    tick(); chk("add_t5", INACT ^ M_ICE ^ M_ILB, T5, 1'b0);
    tick(); chk("add_t6", INACT ^ M_EU ^ M_ILA, T6, 1'b0);

    // SUB
    tick(); opcode = 4'b0010;
    chk("sub_t1", INACT ^ M_EP ^ M_IMR, T1, 1'b0);
    tick(); tick(); tick();
    tick(); chk("sub_t5", INACT ^ M_ICE ^ M_ILB, T5, 1'b0);
    tick(); chk("sub_t6", INACT ^ M_EU ^ M_SU ^ M_ILA, T6, 1'b0);

    // OUT
    tick(); opcode = 4'b1110;
    tick(); tick(); tick();
    chk("out_t4", INACT ^ M_EA ^ M_ILO, T4, 1'b0);
    tick(); chk("out_t5", INACT, T5, 1'b0);
    tick(); chk("out_t6", INACT, T6, 1'b0);

    // Pause in T2 of an ADD, then single-step to T5
    tick(); opcode = 4'b0001;
    tick(); chk("pause_t2_run", INACT ^ M_CP, T2, 1'b0);
    run = 1'b0;
    #1 chk("pause_t2_masked", INACT, T2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("pause_hold", INACT, T2, 1'b0);
    end
    step = 1'b1; #1 chk("step1_ctl", INACT ^ M_CP, T2, 1'b0);
    tick(); step = 1'b0; #1 chk("step1_land", INACT, T3, 1'b0);
    step = 1'b1; #1 chk("step2_ctl", INACT ^ M_ICE ^ M_ILI, T3, 1'b0);
    tick(); step = 1'b0; #1 chk("step2_land", INACT, T4, 1'b0);
    step = 1'b1; #1 chk("step3_ctl", INACT ^ M_IEI ^ M_IMR, T4, 1'b0);
    tick(); step = 1'b0; #1 chk("step3_land", INACT, T5, 1'b0);
    tick(); chk("step_idle_hold", INACT, T5, 1'b0);
    run = 1'b1; step = 1'b1;
    #1 chk("resume_t5", INACT ^ M_ICE ^ M_ILB, T5, 1'b0);
    tick(); step = 1'b0;
    chk("run_step_one_adv", INACT ^ M_EU ^ M_ILA, T6, 1'b0);

    // Async reset mid-T5 of ADD
    tick(); tick(); tick(); tick(); tick();
    chk("pre_rst_t5", INACT ^ M_ICE ^ M_ILB, T5, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", INACT, T0, 1'b0);
    rst_n = 1'b1;
    #1 chk("post_rst_idle", INACT, T0, 1'b0);
    tick(); chk("post_rst_t1", INACT ^ M_EP ^ M_IMR, T1, 1'b0);

    // Undefined opcode behaves as NOP in T4-T6
    opcode = 4'b0101;
    tick(); tick();
    tick(); chk("nop_t4", INACT, T4, 1'b0);
    tick(); chk("nop_t5", INACT, T5, 1'b0);
    tick(); chk("nop_t6", INACT, T6, 1'b0);
    tick(); chk("nop_next_t1", INACT ^ M_EP ^ M_IMR, T1, 1'b0);

    // HLT
    opcode = 4'b1111;
    tick(); tick();
    tick(); chk("hlt_t4", INACT, T4, 1'b0);
    tick(); chk("hlt_halted", INACT, T0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run  = i[0];
      step = i[1];
      opcode = 4'(i);
      tick(); chk("hlt_sticky", INACT, T0, 1'b1);
    end
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    #1 chk("hlt_cleared", INACT, T0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

Controller-sequencer for the 8-bit SAP-style CPU. It steps a six-T-state machine cycle: fetch (T1–T3) and execute (T4–T6). It decodes the IR opcode into the control word that drives PC, MAR (`IMR` load), RAM, IR, accumulator, ALU, B and output registers. It is the only source of `IMR` in the design.

## Interface
Parameters:
- `OP_LDA`, default 4'b0000: load accumulator from RAM[operand]
- `OP_ADD`, default 4'b0001: A ← A + RAM[operand]
- `OP_SUB`, default 4'b0010: A ← A − RAM[operand]
- `OP_OUT`, default 4'b1110: output register ← A
- `OP_HLT`, default 4'b1111: halt

Ports:
- `clk` in 1: single system clock; all state changes on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `run` in 1: free-run enable, level
- `step` in 1: single-step pulse; one cycle high = one T-state advance
- `opcode` in 4: IR upper nibble
- `CP` out 1: PC increment, active-high
- `EP` out 1: PC to bus, active-high
- `IMR` out 1: MAR load, active-low
- `ICE` out 1: RAM to bus, active-low
- `ILI`, `IEI` out 1 each: IR load / IR operand to bus, active-low
- `ILA` out 1: A load, active-low
- `EA` out 1: A to bus, active-high
- `SU` out 1: ALU subtract select
- `EU` out 1: ALU to bus
- `ILB`, `ILO` out 1 each: B load / output register load, active-low
- `HLT` out 1: halted flag
- `t_state` out 6: one-hot current T-state, T1 = bit 0

## Operation
- States: IDLE, T1–T6, HALT. Reset → IDLE.
- Advance enable is `en = run | step`. States change only when `en` is high. Without `en`, the state holds.
- Transitions:
  - IDLE→T1
  - Tn→Tn+1
  - T6→T1
  - T4→HALT when `opcode == OP_HLT`
  - HALT is sticky until `rst_n` is low. `run` and `step` are ignored in HALT.
- Control word is a combinational decode of (state, `opcode`), masked by `en`. When `en` is 0, all controls are inactive: active-high outputs 0, active-low outputs 1.
- Per-state controls (all unlisted controls inactive):
  - T1: `EP`, `IMR`=0
  - T2: `CP`
  - T3: `ICE`=0, `ILI`=0
  - LDA:
    - T4: `IEI`=0, `IMR`=0
    - T5: `ICE`=0, `ILA`=0
    - T6: none
  - ADD:
    - T4: `IEI`=0, `IMR`=0
    - T5: `ICE`=0, `ILB`=0
    - T6: `EU`, `ILA`=0
  - SUB: same as ADD, plus `SU`=1 in T6.
  - OUT:
    - T4: `EA`, `ILO`=0
    - T5, T6: none
  - Undefined opcodes: T4–T6 produce no controls (NOP), and the sequence continues.
- `opcode` is used directly in T4–T6. IR is stable there, because it is loaded only in T3.
- `HLT`=1 exactly when the state is HALT.
- `t_state` is 0 in IDLE and HALT.

## Timing
- Reset values: state IDLE, every control inactive, `HLT`=0, `t_state`=0.
- Reset is asynchronous. Asserting it mid-instruction immediately forces the reset values. The instruction is abandoned, and PC/MAR contents are untouched by this block.
- With `run` held high, the first rising edge after reset release enters T1. Each instruction then takes exactly 6 cycles, back-to-back.
- `HLT` goes high 4 cycles after T1 entry of the HLT instruction: it is observed in the cycle following T4.
- Controls are valid for the whole cycle of their state. The datapath captures them on the rising edge that ends that cycle.
- `run` dropped mid-instruction: the state freezes and controls go inactive in the same cycle. Execution resumes at the same T-state when `en` returns. No micro-op is repeated or skipped.
- `step` with `run` high is redundant: still one advance per cycle.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants
  - state enum (IDLE, T1–T6, HALT)
  - control-word bit indices and the inactive control-word constant
- Sub-module `ctrl_decode`: purely combinational (state, opcode) → control word.
- The top level holds the state register, the `en` mask, `t_state` and `HLT`.

## Test plan
- Reset, `run`=1, opcode 0000 (LDA):
  - cycle 1: `EP`=1, `IMR`=0
  - cycle 2: `CP`=1
  - cycle 3: `ICE`=0, `ILI`=0
  - cycle 4: `IEI`=0, `IMR`=0
  - cycle 5: `ICE`=0, `ILA`=0
  - cycle 6: no controls
  - cycle 7: back in T1
- Opcode 0010 (SUB): T5 `ILB`=0; T6 `EU`=1, `SU`=1, `ILA`=0. Opcode 0001 (ADD) gives the same with `SU`=0.
- Opcode 1111 (HLT): `HLT`=1 after T4, `t_state`=0. Toggling `run`/`step` for 20 cycles changes nothing. `rst_n` low clears `HLT`.
- `run`=0 during T2: `CP`=0, `t_state`=6'b000010 held for 5 cycles. Three `step` pulses reach T5 with the correct per-cycle controls.
- `rst_n` pulsed low during T5 of ADD (asynchronously, mid-cycle): controls go inactive immediately, `t_state`=0, and T1 follows the next enabled edge.
- Opcode 0101 (undefined): T4–T6 have all controls inactive, and the next T1 asserts `EP`/`IMR` normally.
